piso_tx: RTL

PISO_TX -- requirements
Module: piso_tx

---
 rtl/piso_tx.sv | 103 ++++++++++
 1 files changed

// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - parallel-in serial-out framed transmitter (start, LSB-first data, stop)
module piso_tx #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              i_rstn,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    output logic              o_serial,
    output logic              o_busy,
    output logic              o_done
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [IDX_W-1:0]  idx, idx_d;
    logic [DATA_W-1:0] shreg, shreg_d;
    logic              serial_q, serial_d;
    logic              done_q, done_d;
    logic              tick;

    assign tick = (cnt == CNT_LAST);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        shreg_d = shreg;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    state_d = START;
                    shreg_d = i_data;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            START: begin
                cnt_d = tick ? '0 : cnt + CNT_W'(1);
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                cnt_d = tick ? '0 : cnt + CNT_W'(1);
                if (tick) begin
                    shreg_d = shreg >> 1;
                    if (idx == IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                cnt_d = tick ? '0 : cnt + CNT_W'(1);
                if (tick) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    idx_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Line level follows the state being entered so o_serial stays a pure register output.
        serial_d = (state_d == START) ? 1'b0 :
                   (state_d == DATA)  ? shreg_d[0] : 1'b1;
    end

    always_ff @(posedge clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            shreg    <= '0;
            serial_q <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            idx      <= idx_d;
            shreg    <= shreg_d;
            serial_q <= serial_d;
            done_q   <= done_d;
        end
    end

    assign o_ready  = (state == IDLE);
    assign o_busy   = !o_ready;
    assign o_serial = serial_q;
    assign o_done   = done_q;

endmodule
